// File: rtl/xrv_pkg.sv
// Shared types and default constants for the data-bus arbiter.
package xrv_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam int unsigned TIMEOUT_CYC_DEF = 256;
    localparam logic [DATA_W-1:0] ERR_RD_DATA_DEF = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/xrv_dbus_arb.sv
// Two-master round-robin arbiter for the shared data-memory port, with bus-timeout watchdog.
module xrv_dbus_arb
    import xrv_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter logic [DATA_W-1:0] ERR_RD_DATA = ERR_RD_DATA_DEF
) (
    input  logic              clk,
    input  logic              rstb,

    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_wr_req,
    input  logic [BE_W-1:0]   m0_be,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_wr_ready,
    input  logic              m0_rd_req,
    output logic              m0_rd_ready,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_err,

    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_wr_req,
    input  logic [BE_W-1:0]   m1_be,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_wr_ready,
    input  logic              m1_rd_req,
    output logic              m1_rd_ready,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_err,

    output logic [ADDR_W-1:0] s_addr,
    output logic              s_wr_req,
    output logic [BE_W-1:0]   s_be,
    output logic [DATA_W-1:0] s_wr_data,
    input  logic              s_wr_ready,
    output logic              s_rd_req,
    input  logic              s_rd_ready,
    input  logic [DATA_W-1:0] s_rd_data
);

    localparam bit          WDOG_EN  = (TIMEOUT_CYC != 0);
    localparam int unsigned CNT_W    = WDOG_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int unsigned CNT_LAST = WDOG_EN ? TIMEOUT_CYC - 1 : 0;

    arb_state_e       state_q;
    logic             last_q;      // index of the master served most recently
    logic [CNT_W-1:0] cnt_q;

    logic act0, act1, gnt0, gnt1, granted, cur_act, s_rdy, to_hit, done;

    assign act0    = m0_rd_req | m0_wr_req;
    assign act1    = m1_rd_req | m1_wr_req;
    assign gnt0    = (state_q == GNT0);
    assign gnt1    = (state_q == GNT1);
    assign granted = gnt0 | gnt1;
    assign cur_act = gnt1 ? act1 : act0;
    assign s_rdy   = s_wr_ready | s_rd_ready;

    // Watchdog fires on the last allowed grant cycle if the slave is still silent.
    assign to_hit = WDOG_EN && granted && cur_act && !s_rdy
                    && (cnt_q == CNT_W'(CNT_LAST));
    assign done   = granted && ((cur_act && s_rdy) || to_hit);

    // Slave side follows the granted master; master 0 is parked on the bus when idle.
    assign s_addr    = gnt1 ? m1_addr    : m0_addr;
    assign s_be      = gnt1 ? m1_be      : m0_be;
    assign s_wr_data = gnt1 ? m1_wr_data : m0_wr_data;
    assign s_wr_req  = (gnt0 & m0_wr_req) | (gnt1 & m1_wr_req);
    assign s_rd_req  = (gnt0 & m0_rd_req) | (gnt1 & m1_rd_req);

    // Completion pulses: slave ready or the forced watchdog completion.
    assign m0_wr_ready = gnt0 & (s_wr_ready | (to_hit & m0_wr_req));
    assign m0_rd_ready = gnt0 & (s_rd_ready | (to_hit & m0_rd_req));
    assign m1_wr_ready = gnt1 & (s_wr_ready | (to_hit & m1_wr_req));
    assign m1_rd_ready = gnt1 & (s_rd_ready | (to_hit & m1_rd_req));
    assign m0_err      = gnt0 & to_hit;
    assign m1_err      = gnt1 & to_hit;
    assign m0_rd_data  = (gnt0 & to_hit) ? ERR_RD_DATA : s_rd_data;
    assign m1_rd_data  = (gnt1 & to_hit) ? ERR_RD_DATA : s_rd_data;

    // Grant FSM, round-robin pointer and watchdog counter.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (act0 && act1)  state_q <= last_q ? GNT0 : GNT1;
                    else if (act0)     state_q <= GNT0;
                    else if (act1)     state_q <= GNT1;
                end
                GNT0: begin
                    if (done) begin
                        last_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= act1 ? GNT1 : IDLE;
                    end else if (!act0) begin
                        state_q <= IDLE;
                    end else if (WDOG_EN) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                GNT1: begin
                    if (done) begin
                        last_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= act0 ? GNT0 : IDLE;
                    end else if (!act1) begin
                        state_q <= IDLE;
                    end else if (WDOG_EN) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // A master must never request a read and a write in the same cycle.
    always_ff @(posedge clk) begin
        if (rstb) begin
            a_m0_rdwr: assert (!(m0_rd_req && m0_wr_req));
            a_m1_rdwr: assert (!(m1_rd_req && m1_wr_req));
        end
    end

endmodule

// File: tb/tb_xrv_dbus_arb.sv
// Directed self-checking bench for xrv_dbus_arb (cycle table plus watchdog sequence).
module tb_xrv_dbus_arb;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;
    localparam logic [31:0] D0 = 32'h1234_5678;
    localparam logic [31:0] D1 = 32'hCAFE_F00D;

    // input bits {m0_rd, m0_wr, m1_rd, m1_wr, s_wr_ready, s_rd_ready}
    localparam logic [5:0] M0RD = 6'b100000;
    localparam logic [5:0] M0WR = 6'b010000;
    localparam logic [5:0] M1RD = 6'b001000;
    localparam logic [5:0] M1WR = 6'b000100;
    localparam logic [5:0] SWR  = 6'b000010;
    localparam logic [5:0] SRD  = 6'b000001;

    // expected bits {s_wr_req, s_rd_req, m0_wr_rdy, m0_rd_rdy, m1_wr_rdy, m1_rd_rdy, m0_err, m1_err}
    localparam logic [7:0] E_SWR  = 8'h80;
    localparam logic [7:0] E_SRD  = 8'h40;
    localparam logic [7:0] E_M0WR = 8'h20;
    localparam logic [7:0] E_M0RD = 8'h10;
    localparam logic [7:0] E_M1WR = 8'h08;
    localparam logic [7:0] E_M1RD = 8'h04;

    typedef struct {
        logic        rst_n;
        logic [5:0]  in;
        logic [31:0] rdata;
        logic [7:0]  exp;
        logic [31:0] exp_addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstb;
    logic [31:0] m0_addr, m0_wr_data, m1_addr, m1_wr_data, s_addr, s_wr_data, s_rd_data;
    logic [31:0] m0_rd_data, m1_rd_data;
    logic [3:0]  m0_be, m1_be, s_be;
    logic        m0_wr_req, m0_rd_req, m0_wr_ready, m0_rd_ready, m0_err;
    logic        m1_wr_req, m1_rd_req, m1_wr_ready, m1_rd_ready, m1_err;
    logic        s_wr_req, s_rd_req, s_wr_ready, s_rd_ready;

    int errors = 0;
    int checks = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    xrv_dbus_arb #(.TIMEOUT_CYC(8), .ERR_RD_DATA(32'h0)) dut (
        .clk(clk), .rstb(rstb),
        .m0_addr(m0_addr), .m0_wr_req(m0_wr_req), .m0_be(m0_be), .m0_wr_data(m0_wr_data),
        .m0_wr_ready(m0_wr_ready), .m0_rd_req(m0_rd_req), .m0_rd_ready(m0_rd_ready),
        .m0_rd_data(m0_rd_data), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_wr_req(m1_wr_req), .m1_be(m1_be), .m1_wr_data(m1_wr_data),
        .m1_wr_ready(m1_wr_ready), .m1_rd_req(m1_rd_req), .m1_rd_ready(m1_rd_ready),
        .m1_rd_data(m1_rd_data), .m1_err(m1_err),
        .s_addr(s_addr), .s_wr_req(s_wr_req), .s_be(s_be), .s_wr_data(s_wr_data),
        .s_wr_ready(s_wr_ready), .s_rd_req(s_rd_req), .s_rd_ready(s_rd_ready),
        .s_rd_data(s_rd_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [5:0] in, input logic [31:0] rd,
                       input logic [7:0] exp, input logic [31:0] addr);
        vec_t v;
        v.rst_n = r; v.in = in; v.rdata = rd; v.exp = exp; v.exp_addr = addr;
        vq.push_back(v);
    endtask

    initial begin
        rstb = 1'b0;
        m0_addr = A0; m0_be = 4'hF; m0_wr_data = D0;
        m1_addr = A1; m1_be = 4'h3; m1_wr_data = D1;
        {m0_rd_req, m0_wr_req, m1_rd_req, m1_wr_req, s_wr_ready, s_rd_ready} = '0;
        s_rd_data = '0;

        // m0 single write, slave ready two cycles after s_wr_req
        add(1, 0, 0, 0, A0);
        add(1, M0WR, 0, 0, A0);
        add(1, M0WR, 0, E_SWR, A0);
        add(1, M0WR, 0, E_SWR, A0);
        add(1, M0WR | SWR, 0, E_SWR | E_M0WR, A0);
        add(1, 0, 0, 0, A0);

        // after reset, tie m0 read vs m1 write: m0 first, then m1 with no bubble
        add(0, 0, 0, 0, A0);
        add(1, M0RD | M1WR, 0, 0, A0);
        add(1, M0RD | M1WR, 0, E_SRD, A0);
        add(1, M0RD | M1WR | SRD, 32'hA5A5_0001, E_SRD | E_M0RD, A0);
        add(1, M1WR, 0, E_SWR, A1);
        add(1, M1WR | SWR, 0, E_SWR | E_M1WR, A1);
        add(1, 0, 0, 0, A0);

        // 4 reads per master, alternating grants
        add(1, M0RD | M1RD, 0, 0, A0);
        for (int k = 0; k < 8; k++) begin
            logic [5:0] base;
            logic       g;
            g    = k[0];
            base = ((k <= 6) ? M0RD : 6'b0) | M1RD;
            add(1, base, 0, E_SRD, g ? A1 : A0);
            add(1, base | SRD, 32'h5A00_0000 + 32'(k), E_SRD | (g ? E_M1RD : E_M0RD), g ? A1 : A0);
        end
        add(1, 0, 0, 0, A0);

        // m1 aborts its write in the 2nd grant cycle; pending m0 read follows
        add(1, M1WR, 0, 0, A0);
        add(1, M1WR, 0, E_SWR, A1);
        add(1, M0RD, 0, 0, A1);
        add(1, M0RD, 0, 0, A0);
        add(1, M0RD, 0, E_SRD, A0);
        add(1, M0RD | SRD, 32'h0BAD_0002, E_SRD | E_M0RD, A0);
        add(1, 0, 0, 0, A0);

        // reset during GNT1, then both active: m0 wins
        add(1, M1RD, 0, 0, A0);
        add(1, M1RD, 0, E_SRD, A1);
        add(0, M0WR | M1RD, 0, 0, A0);
        add(1, M0WR | M1RD, 0, 0, A0);
        add(1, M0WR | M1RD, 0, E_SWR, A0);
        add(1, M0WR | M1RD | SWR, 0, E_SWR | E_M0WR, A0);
        add(1, M1RD | SRD, 32'h7777_0003, E_SRD | E_M1RD, A1);
        add(1, 0, 0, 0, A0);
        // slave ready while idle is ignored
        add(1, SWR | SRD, 32'h1111_2222, 0, A0);
        add(1, 0, 0, 0, A0);

        repeat (2) @(posedge clk);
        #1 rstb = 1'b1;

        foreach (vq[i]) begin
            logic [7:0] act;
            @(posedge clk);
            #1;
            rstb = vq[i].rst_n;
            {m0_rd_req, m0_wr_req, m1_rd_req, m1_wr_req, s_wr_ready, s_rd_ready} = vq[i].in;
            s_rd_data = vq[i].rdata;
            @(negedge clk);
            act = {s_wr_req, s_rd_req, m0_wr_ready, m0_rd_ready,
                   m1_wr_ready, m1_rd_ready, m0_err, m1_err};
            chk($sformatf("row%0d flags", i), 32'(act), 32'(vq[i].exp));
            chk($sformatf("row%0d s_addr", i), s_addr, vq[i].exp_addr);
            chk($sformatf("row%0d s_wr_data", i), s_wr_data, (vq[i].exp_addr == A1) ? D1 : D0);
            chk($sformatf("row%0d s_be", i), 32'(s_be), (vq[i].exp_addr == A1) ? 32'h3 : 32'hF);
            chk($sformatf("row%0d m0_rd_data", i), m0_rd_data, vq[i].rdata);
            chk($sformatf("row%0d m1_rd_data", i), m1_rd_data, vq[i].rdata);
        end

        // watchdog: m1 reads, slave silent, forced error on the 8th grant cycle
        @(posedge clk);
        #1;
        m1_rd_req = 1'b1;
        s_rd_data = 32'hDEAD_BEEF;
        {m0_rd_req, m0_wr_req, m1_wr_req, s_wr_ready, s_rd_ready} = '0;
        @(negedge clk);
        chk("wd idle s_rd_req", 32'(s_rd_req), 32'h0);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("wd c%0d s_rd_req", c), 32'(s_rd_req), 32'h1);
            chk($sformatf("wd c%0d m1_rd_ready", c), 32'(m1_rd_ready), (c == 8) ? 32'h1 : 32'h0);
            chk($sformatf("wd c%0d m1_err", c), 32'(m1_err), (c == 8) ? 32'h1 : 32'h0);
            if (c == 8) begin
                chk("wd m1_rd_data", m1_rd_data, 32'h0);
                chk("wd m0_rd_data", m0_rd_data, 32'hDEAD_BEEF);
                chk("wd m0_err", 32'(m0_err), 32'h0);
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("wd after s_rd_req", 32'(s_rd_req), 32'h0);
        chk("wd after m1_rd_ready", 32'(m1_rd_ready), 32'h0);
        chk("wd after m1_err", 32'(m1_err), 32'h0);
        #1 m1_rd_req = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xrv_dbus_arb.md
Name: xrv_dbus_arb

Overview:
- Two-master arbiter that shares the single data-memory port between the core execute stage (m0) and a DMA/debug requester (m1).
- Both sides use the core's req/ready protocol. Req is held until a one-cycle ready pulse arrives. Read data is valid in the ready cycle.
- Adds round-robin fairness, back-to-back handoff and a bus-timeout watchdog.
- Sits between the core data port and the data RAM/peripheral interconnect.

Parameters:
- TIMEOUT_CYC, 256: number of grant cycles without slave ready before a forced error completion; 0 disables the watchdog.
- ERR_RD_DATA, 32'h0: read data returned on a timed-out read.

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous active-low reset
- mN_addr  in  32  master N byte address (N=0,1)
- mN_wr_req  in  1  master N write request, held until mN_wr_ready
- mN_be  in  4  master N byte enables
- mN_wr_data  in  32  master N write data
- mN_wr_ready  out  1  write completion pulse to master N
- mN_rd_req  in  1  master N read request, held until mN_rd_ready
- mN_rd_ready  out  1  read completion pulse to master N
- mN_rd_data  out  32  read data to master N
- mN_err  out  1  timeout flag, coincident with the forced ready pulse
- s_addr  out  32  slave address
- s_wr_req  out  1  slave write request
- s_be  out  4  slave byte enables
- s_wr_data  out  32  slave write data
- s_wr_ready  in  1  slave write completion
- s_rd_req  out  1  slave read request
- s_rd_ready  in  1  slave read completion
- s_rd_data  in  32  slave read data

Behaviour:
- Reset is rstb, asynchronous, active-low; clock is clk.
- Reset values: state IDLE, last-served pointer = 1 (m0 wins the first tie), timeout counter 0. All ready, err and s_*_req outputs are 0.
- States: IDLE, GNT0, GNT1.
- Master "active" = mN_rd_req | mN_wr_req.
- IDLE transitions:
  - Exactly one master active → GNTn next cycle.
  - Both active → grant the master not last served.
  - Neither active → stay in IDLE.
- Grant latency: request first seen at cycle N (state IDLE) → s_*_req asserted from cycle N+1.
- In GNTn:
  - s_addr, s_be, s_wr_data, s_wr_req and s_rd_req are driven combinationally from master n.
  - In IDLE, s_* requests are 0; address and data outputs hold master 0's values.
- mn_wr_ready = s_wr_ready & GNTn; mn_rd_ready = s_rd_ready & GNTn. Both are combinational, zero added latency.
- s_rd_data is broadcast to both mN_rd_data.
- Slave ready seen in IDLE, or for the non-granted master, is ignored.
- On completion (slave ready in GNTn):
  - Last-served pointer ← n.
  - If the other master is active this cycle → GNT(other) next cycle, with no idle bubble.
  - Otherwise → IDLE.
  - Master n's own req, still high in the completion cycle, is never re-granted on it.
- Abort: the granted master's req drops without a ready → s_*_req drops in the same cycle (combinational), state → IDLE next cycle, pointer unchanged.
- Watchdog:
  - Counter clears on every grant entry and increments each grant cycle without slave ready.
  - When TIMEOUT_CYC grant cycles have elapsed with no ready, in that cycle the arbiter asserts mn_rd_ready or mn_wr_ready (matching the held req) plus mn_err. mn_rd_data = ERR_RD_DATA for that cycle.
  - Next cycle the state follows the completion rules; the slave req is withdrawn.
  - Counter width is $clog2(TIMEOUT_CYC+1).
- Master asserting rd_req and wr_req together is illegal. Both are forwarded unchanged and a simulation assertion fires.
- Reset mid-transfer: all outputs return to reset values immediately. The slave must tolerate req withdrawal.
- Slave must not pulse ready after its req has been withdrawn.

Decomposition:
- xrv_pkg:
  - arb_state_e enum (IDLE, GNT0, GNT1).
  - default constants for TIMEOUT_CYC and ERR_RD_DATA.
- Single module. The round-robin pick and the watchdog are too small to justify a sub-module.

Test Plan:
- m0 writes addr 0x100, be 4'hf, data 0x12345678; slave readies 2 cycles after s_wr_req → s_wr_req rises at N+1, m0_wr_ready pulses in the same cycle as s_wr_ready, m1 readies stay 0, state returns to IDLE.
- After reset, m0 read and m1 write assert together at cycle N → GNT0 at N+1; m1 granted the cycle after m0_rd_ready, with no IDLE cycle between.
- Both masters issue 4 back-to-back reads each, slave ready after 1 cycle → grant order 0,1,0,1,0,1,0,1 and m0_rd_data/m1_rd_data match slave data per beat.
- TIMEOUT_CYC=8, m1 reads, slave never readies → on the 8th grant cycle m1_rd_ready=1, m1_err=1, m1_rd_data=0; s_rd_req=0 the next cycle.
- rstb low during GNT1 → s_rd_req, s_wr_req and all readies 0 immediately; after release with both active, m0 is granted first.
- m1 drops wr_req in its 2nd grant cycle with no ready → s_wr_req falls in the same cycle, state is IDLE next cycle, and a pending m0 request is granted the cycle after.
